cell2_bist: RTL and testbench
=============================

Name: cell2_bist

Overview:
- On-chip stimulus generator and response checker for two-input combinational cells such as NOR2, NAND2, AND2 and OR2 on the gp9t3v3 test chip.
- Drives the A/B inputs of a cell under test (CUT) through all four input vectors in Gray order, then samples the CUT output Y and compares it against a parameterised truth table.
- Reports pass/fail, an error count and the first failing vector. One instance sits beside each CUT; a scan/JTAG controller starts it and reads the results.

Parameters:
- TRUTH, 4'b0001, expected Y indexed by {A,B}: bit0={0,0}, bit1={0,1}, bit2={1,0}, bit3={1,1}. The default is NOR2.
- SETTLE_CYC, 2, extra cycles each vector is held before Y is sampled. Legal range 0..15.
- LOOPS, 16, number of full 4-vector sweeps per run. Must be at least 1.
- CNT_W, 8, width of ERR_CNT.

Ports:
- CLK  input  1  clock; all flops rising-edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle run request.
- A  output  1  CUT input A; registered.
- B  output  1  CUT input B; registered.
- Y  input  1  CUT output; sampled directly, combinational path from A/B.
- BUSY  output  1  run in progress.
- DONE  output  1  run complete; level signal.
- PASS  output  1  valid when DONE; 1 means zero mismatches.
- ERR_CNT  output  CNT_W  saturating mismatch count.
- FAIL_VALID  output  1  a mismatch has been captured this run.
- FAIL_VEC  output  2  {A,B} of the first mismatch.

Behaviour:
- Reset values: A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0. State returns to IDLE and all counters clear.
- RST asserted mid-run aborts the run immediately. The reset values apply on the next edge and no partial results are retained.
- FSM states: IDLE, HOLD, FINISH.
- IDLE:
  - Vector index = 0 and {A,B}=00.
  - START=1 causes a transition to HOLD and clears ERR_CNT, FAIL_VALID, FAIL_VEC, DONE and PASS.
  - BUSY=1 from the next cycle.
- HOLD:
  - {A,B} follows the Gray sequence 00, 01, 11, 10 by vector index 0..3.
  - Each vector is held for exactly SETTLE_CYC+1 cycles. A settle counter counts 0..SETTLE_CYC.
  - On the edge where the settle counter equals SETTLE_CYC, Y is compared with TRUTH[{A,B}].
  - Mismatch: ERR_CNT increments, saturating at 2^CNT_W-1. If FAIL_VALID=0, FAIL_VEC is set to {A,B} and FAIL_VALID is set to 1.
  - On that same edge the next vector is driven. After index 3, the loop counter increments.
  - After the compare of the last vector of loop LOOPS-1, the FSM moves to FINISH.
- FINISH:
  - BUSY=0, DONE=1, PASS=(ERR_CNT==0 including the final compare), {A,B}=00.
  - Results stay stable until the next START or RST. The FSM goes to IDLE while outputs hold; the results are cleared only when a new run starts.
- Timing: START sampled at edge 0. BUSY=1 during cycles 1..N, where N=LOOPS*4*(SETTLE_CYC+1). DONE=1 from cycle N+1. With defaults, N=192.
- START while BUSY=1 is ignored and does not restart the run. START in the same cycle as RST: RST wins.
- Y is treated as valid only at the compare edge. It is never sampled in IDLE or FINISH.
- The loop counter width is clog2(LOOPS)+1. The settle counter is 4 bits.

Test Plan:
- Ideal NOR model on Y, defaults, pulse START -> A/B cycle 00,01,11,10 with each held 3 cycles; BUSY high for 192 cycles; DONE=1 at cycle 193; PASS=1, ERR_CNT=0, FAIL_VALID=0.
- Y stuck at 0, defaults -> one mismatch per loop at vector 00; ERR_CNT=16, PASS=0, FAIL_VALID=1, FAIL_VEC=2'b00.
- Y stuck at 1, CNT_W=4 -> 3 mismatches per loop (48 total); ERR_CNT saturates at 15; FAIL_VEC=2'b01 (first failing Gray vector).
- TRUTH=4'b0111 (NAND2), SETTLE_CYC=0, LOOPS=1, ideal NAND model -> BUSY for 4 cycles, DONE at cycle 5, PASS=1.
- RST asserted at cycle 50 of a default run, then START again -> all outputs at reset values the cycle after RST; the second run completes normally with PASS=1 and ERR_CNT=0.
- START re-pulsed at cycles 10 and 100 during a run -> no restart; DONE still at cycle 193. A START after DONE clears the results and begins a new run.

Source files
------------

// File: rtl/cell2_bist.sv
// Stimulus generator and response checker for a two-input combinational cell.
// Sweeps {A,B} through the Gray sequence 00,01,11,10, samples Y at the end of
// each vector's settle window and compares it with the TRUTH table.
module cell2_bist #(
  parameter logic [3:0]  TRUTH      = 4'b0001,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned LOOPS      = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             A,
  output logic             B,
  input  logic             Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [1:0]       FAIL_VEC
);

  localparam int unsigned       LOOP_W      = $clog2(LOOPS) + 1;
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [3:0]        settle_q, settle_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [1:0]        ab_q, ab_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fv_q, fv_d;
  logic [1:0]        fvec_q, fvec_d;
  logic              mismatch_c;

  // Vector index to {A,B} in Gray order.
  function automatic logic [1:0] gray(input logic [1:0] idx);
    return {idx[1], idx[1] ^ idx[0]};
  endfunction

  // State and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      loop_q   <= '0;
      ab_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      loop_q   <= loop_d;
      ab_q     <= ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      fvec_q   <= fvec_d;
    end
  end

  // Next-state, sweep sequencing and compare logic.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    loop_d     = loop_q;
    ab_d       = ab_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fv_d       = fv_q;
    fvec_d     = fvec_q;
    mismatch_c = 1'b0;

    case (state_q)
      IDLE, FINISH: begin
        // Results from the last run are held until a new START arrives.
        vec_d    = '0;
        settle_d = '0;
        loop_d   = '0;
        ab_d     = 2'b00;
        if (state_q == FINISH) begin
          state_d = IDLE;
        end
        if (START) begin
          state_d = HOLD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end

      HOLD: begin
        if (settle_q == SETTLE_LAST) begin
          mismatch_c = (Y != TRUTH[ab_q]);
          if (mismatch_c) begin
            if (err_q != CNT_MAX) begin
              err_d = err_q + CNT_W'(1);
            end
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = ab_q;
            end
          end
          settle_d = '0;
          vec_d    = vec_q + 2'd1;
          ab_d     = gray(vec_q + 2'd1);
          if (vec_q == 2'd3) begin
            loop_d = loop_q + LOOP_W'(1);
            if (loop_q == LOOP_LAST) begin
              state_d = FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_q == '0) && !mismatch_c;
              ab_d    = 2'b00;
            end
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign A          = ab_q[1];
  assign B          = ab_q[0];
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FAIL_VALID = fv_q;
  assign FAIL_VEC   = fvec_q;

endmodule

// File: tb/tb_cell2_bist.sv
// Bench for cell2_bist: three instances (NOR default, NOR with 4-bit counter,
// NAND single sweep) beside a behavioural CUT/result model.
module tb_cell2_bist;

  localparam int NI = 3;
  localparam logic [3:0] TR [NI] = '{4'b0001, 4'b0001, 4'b0111};
  localparam int SC [NI] = '{2, 2, 0};
  localparam int LP [NI] = '{16, 16, 1};
  localparam int CW [NI] = '{8, 4, 8};
  localparam int EXP_AB [12] = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 2, 2, 2};

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [NI-1:0] a_s, b_s, busy_s, done_s, pass_s, fv_s;
  logic [1:0] fvec_s [NI];
  logic [7:0] err0, err2;
  logic [3:0] err1;
  logic y0, y1, y2;
  logic [1:0] mode [NI];
  logic [NI-1:0] yr;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Reference model state: position within the run in cycles.
  int m_p [NI];
  int m_err [NI];
  int m_tot [NI];
  bit m_busy [NI], m_done [NI], m_pass [NI], m_fv [NI];
  bit [1:0] m_fvec [NI], m_ab [NI];

  always #5 clk = ~clk;

  // CUT behaviour: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 random.
  function automatic logic cut_y(input logic [1:0] m, input logic r,
                                 input logic [3:0] t, input logic a, input logic b);
    case (m)
      2'd0:    return t[{a, b}];
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return r;
    endcase
  endfunction

  function automatic bit [1:0] gray(input int k);
    return 2'(k ^ (k >> 1));
  endfunction

  assign y0 = cut_y(mode[0], yr[0], TR[0], a_s[0], b_s[0]);
  assign y1 = cut_y(mode[1], yr[1], TR[1], a_s[1], b_s[1]);
  assign y2 = cut_y(mode[2], yr[2], TR[2], a_s[2], b_s[2]);

  cell2_bist #(.TRUTH(4'b0001), .SETTLE_CYC(2), .LOOPS(16), .CNT_W(8)) u_nor (
    .CLK(clk), .RST(rst), .START(start), .A(a_s[0]), .B(b_s[0]), .Y(y0),
    .BUSY(busy_s[0]), .DONE(done_s[0]), .PASS(pass_s[0]), .ERR_CNT(err0),
    .FAIL_VALID(fv_s[0]), .FAIL_VEC(fvec_s[0]));

  cell2_bist #(.TRUTH(4'b0001), .SETTLE_CYC(2), .LOOPS(16), .CNT_W(4)) u_nor_c4 (
    .CLK(clk), .RST(rst), .START(start), .A(a_s[1]), .B(b_s[1]), .Y(y1),
    .BUSY(busy_s[1]), .DONE(done_s[1]), .PASS(pass_s[1]), .ERR_CNT(err1),
    .FAIL_VALID(fv_s[1]), .FAIL_VEC(fvec_s[1]));

  cell2_bist #(.TRUTH(4'b0111), .SETTLE_CYC(0), .LOOPS(1), .CNT_W(8)) u_nand (
    .CLK(clk), .RST(rst), .START(start), .A(a_s[2]), .B(b_s[2]), .Y(y2),
    .BUSY(busy_s[2]), .DONE(done_s[2]), .PASS(pass_s[2]), .ERR_CNT(err2),
    .FAIL_VALID(fv_s[2]), .FAIL_VEC(fvec_s[2]));

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pack_act(input int i);
    logic [7:0] e;
    case (i)
      0:       e = err0;
      1:       e = {4'b0000, err1};
      default: e = err2;
    endcase
    return int'({a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i], fv_s[i], fvec_s[i], e});
  endfunction

  function automatic int pack_exp(input int i);
    return int'({m_ab[i], m_busy[i], m_done[i], m_pass[i], m_fv[i], m_fvec[i], 8'(m_err[i])});
  endfunction

  // Reference model: derives vector, compare points and results from run position.
  always @(posedge clk) begin
    int sc, n;
    bit [1:0] cur;
    logic y;
    for (int i = 0; i < NI; i++) begin
      sc = SC[i] + 1;
      n  = LP[i] * 4 * sc;
      if (rst) begin
        m_p[i] = 0; m_err[i] = 0; m_tot[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fv[i] = 0;
        m_fvec[i] = 0; m_ab[i] = 0;
      end else if (m_busy[i]) begin
        cur = gray((m_p[i] / sc) % 4);
        if (m_p[i] % sc == SC[i]) begin
          y = cut_y(mode[i], yr[i], TR[i], cur[1], cur[0]);
          if (y !== TR[i][cur]) begin
            m_tot[i]++;
            if (m_err[i] < (1 << CW[i]) - 1) m_err[i]++;
            if (!m_fv[i]) begin
              m_fv[i]   = 1;
              m_fvec[i] = cur;
            end
          end
        end
        m_p[i]++;
        if (m_p[i] == n) begin
          m_busy[i] = 0;
          m_done[i] = 1;
          m_pass[i] = (m_tot[i] == 0);
          m_ab[i]   = 0;
        end else begin
          m_ab[i] = gray((m_p[i] / sc) % 4);
        end
      end else if (start) begin
        m_busy[i] = 1; m_p[i] = 0; m_err[i] = 0; m_tot[i] = 0;
        m_fv[i] = 0; m_fvec[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_ab[i] = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("inst%0d_outputs", i), pack_act(i), pack_exp(i));
      end
    end
  end

  // Watch one run started at the preceding edge; returns busy length and DONE cycle.
  task automatic run_watch(input bit first, input bit repulse, output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = repulse && (c == 10 || c == 100);
      if (c == 1) begin
        chk("run_busy_c1", int'(busy_s[0]), 1);
        chk("run_done_cleared", int'(done_s[0]), 0);
        chk("run_pass_cleared", int'(pass_s[0]), 0);
      end
      if (first && c <= 12) chk($sformatf("gray_ab_c%0d", c), int'({a_s[0], b_s[0]}), EXP_AB[c-1]);
      if (first && c <= 4) chk("nand_busy", int'(busy_s[2]), 1);
      if (first && c == 5) begin
        chk("nand_done_c5", int'(done_s[2]), 1);
        chk("nand_pass", int'(pass_s[2]), 1);
        chk("nand_busy_c5", int'(busy_s[2]), 0);
      end
      if (busy_s[0]) bc++;
      if (done_s[0]) begin
        dc = c;
        break;
      end
    end
    if (dc == 0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int bc, dc;
    rst = 1'b1;
    start = 1'b0;
    yr = '0;
    for (int i = 0; i < NI; i++) mode[i] = 2'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("reset_inst%0d", i), pack_act(i), 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Ideal NOR / stuck-at-1 NOR with 4-bit counter / ideal NAND.
    mode[0] = 2'd0; mode[1] = 2'd2; mode[2] = 2'd0;
    start = 1'b1;
    run_watch(1'b1, 1'b0, bc, dc);
    chk("busy_len", bc, 192);
    chk("done_cycle", dc, 193);
    chk("nor_pass", int'(pass_s[0]), 1);
    chk("nor_err", int'(err0), 0);
    chk("nor_fv", int'(fv_s[0]), 0);
    chk("sat_err", int'(err1), 15);
    chk("sat_fv", int'(fv_s[1]), 1);
    chk("sat_fvec", int'(fvec_s[1]), 1);
    chk("sat_pass", int'(pass_s[1]), 0);

    // Stuck-at-0 with START re-pulsed mid-run.
    mode[0] = 2'd1; mode[1] = 2'd0;
    start = 1'b1;
    run_watch(1'b0, 1'b1, bc, dc);
    chk("repulse_done_cycle", dc, 193);
    chk("s0_err", int'(err0), 16);
    chk("s0_fv", int'(fv_s[0]), 1);
    chk("s0_fvec", int'(fvec_s[0]), 0);
    chk("s0_pass", int'(pass_s[0]), 0);

    // Reset at cycle 50, then a clean rerun.
    mode[0] = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_err_cleared", int'(err0), 0);
    chk("rerun_fv_cleared", int'(fv_s[0]), 0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("midrun_reset_inst%0d", i), pack_act(i), 0);
    rst = 1'b0;
    start = 1'b1;
    run_watch(1'b0, 1'b0, bc, dc);
    chk("after_reset_done_cycle", dc, 193);
    chk("after_reset_pass", int'(pass_s[0]), 1);
    chk("after_reset_err", int'(err0), 0);

    // Randomized runs: random CUT faults, stray STARTs and occasional resets.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NI; i++) mode[i] = 2'($urandom_range(3));
      repeat ($urandom_range(5)) @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 220; c++) begin
        @(negedge clk);
        start = ($urandom_range(15) == 0);
        rst   = ($urandom_range(299) == 0);
        yr    = 3'($urandom);
      end
      start = 1'b0;
      rst = 1'b0;
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1);
  end

endmodule
